// File: rtl/program_loader.sv
// Framed byte-stream loader for the MC14500B program ROM; holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int unsigned ADDR = 8,
   parameter int unsigned CODE = 4,
   parameter int unsigned WORD = ADDR + CODE
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            reload,
   output logic            program_write,
   output logic [ADDR-1:0] program_addr,
   output logic [WORD-1:0] program_cmd,
   output logic            cpu_run,
   output logic            busy,
   output logic            error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_WR,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

   typedef struct packed {
      logic rdy;
      logic wr;
      logic run;
      logic bsy;
      logic err;
   } flags_t;

   // Outputs are registered alongside the state so each one comes straight off a flop.
   function automatic flags_t flags_of(input state_t s);
      flags_t f;
      f = '0;
      case (s)
         S_IDLE:     f.rdy = 1'b1;
         S_LO, S_HI: begin f.rdy = 1'b1; f.bsy = 1'b1; end
         S_WR:       begin f.wr  = 1'b1; f.bsy = 1'b1; end
`ifdef LOADER_CHECKSUM_EN
         S_CHK:      begin f.rdy = 1'b1; f.bsy = 1'b1; end
`endif
         S_DONE:     f.run = 1'b1;
         S_ERR:      f.err = 1'b1;
         default:    f = '0;
      endcase
      return f;
   endfunction

   state_t          state_q;
   flags_t          flags_q;
   logic [ADDR-1:0] addr_q;
   logic [WORD-1:0] cmd_q;
   logic [7:0]      lo_q;
   logic [ADDR:0]   rem_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]      csum_q;
`endif

   logic            accept_d;
   logic [8:0]      c_ext_d;
   logic [8:0]      full_d;
   logic            c_too_big_d;
   logic [ADDR:0]   n_words_d;
   logic [WORD-1:0] cmd_d;

   always_comb begin
      accept_d    = in_valid && flags_q.rdy;
      c_ext_d     = {1'b0, in_data};
      full_d      = 9'd1 << ADDR;
      c_too_big_d = c_ext_d > full_d;
      n_words_d   = (in_data == 8'd0) ? full_d[ADDR:0] : c_ext_d[ADDR:0];
      cmd_d       = {in_data[WORD-9:0], lo_q};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         flags_q <= flags_of(S_IDLE);
         addr_q  <= '0;
         cmd_q   <= '0;
         lo_q    <= '0;
         rem_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (accept_d) begin
               addr_q <= '0;
               rem_q  <= n_words_d;
`ifdef LOADER_CHECKSUM_EN
               csum_q <= in_data;
`endif
               if (c_too_big_d) begin
                  state_q <= S_ERR;
                  flags_q <= flags_of(S_ERR);
               end else begin
                  state_q <= S_LO;
                  flags_q <= flags_of(S_LO);
               end
            end
            S_LO: if (accept_d) begin
               lo_q    <= in_data;
`ifdef LOADER_CHECKSUM_EN
               csum_q  <= csum_q ^ in_data;
`endif
               state_q <= S_HI;
               flags_q <= flags_of(S_HI);
            end
            S_HI: if (accept_d) begin
               cmd_q   <= cmd_d;
`ifdef LOADER_CHECKSUM_EN
               csum_q  <= csum_q ^ in_data;
`endif
               state_q <= S_WR;
               flags_q <= flags_of(S_WR);
            end
            S_WR: begin
               addr_q <= addr_q + ADDR'(1);
               rem_q  <= rem_q - (ADDR+1)'(1);
               if (rem_q == (ADDR+1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                  state_q <= S_CHK;
                  flags_q <= flags_of(S_CHK);
`else
                  state_q <= S_DONE;
                  flags_q <= flags_of(S_DONE);
`endif
               end else begin
                  state_q <= S_LO;
                  flags_q <= flags_of(S_LO);
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (accept_d) begin
               if (csum_q == in_data) begin
                  state_q <= S_DONE;
                  flags_q <= flags_of(S_DONE);
               end else begin
                  state_q <= S_ERR;
                  flags_q <= flags_of(S_ERR);
               end
            end
`endif
            S_DONE, S_ERR: if (reload) begin
               state_q <= S_IDLE;
               flags_q <= flags_of(S_IDLE);
            end
            default: begin
               state_q <= S_IDLE;
               flags_q <= flags_of(S_IDLE);
            end
         endcase
      end
   end

   assign in_ready      = flags_q.rdy;
   assign program_write = flags_q.wr;
   assign cpu_run       = flags_q.run;
   assign busy          = flags_q.bsy;
   assign error         = flags_q.err;
   assign program_addr  = addr_q;
   assign program_cmd   = cmd_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: one ADDR=8 instance and one ADDR=4 instance.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [7:0]  d8_data = '0, d4_data = '0;
   logic        d8_valid = 1'b0, d4_valid = 1'b0;
   logic        d8_reload = 1'b0, d4_reload = 1'b0;
   logic        rdy8, wr8, run8, busy8, err8;
   logic        rdy4, wr4, run4, busy4, err4;
   logic [7:0]  addr8;
   logic [3:0]  addr4;
   logic [11:0] cmd8, cmd4;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned q8[$];
   int unsigned q4[$];
   logic [7:0]  lo_v[256];
   logic [7:0]  hi_v[256];
   logic        wr8_prev = 1'b0, wr4_prev = 1'b0;

   program_loader #(.ADDR(8), .CODE(4)) u_dut8 (
      .clk(clk), .rst(rst), .in_data(d8_data), .in_valid(d8_valid), .in_ready(rdy8),
      .reload(d8_reload), .program_write(wr8), .program_addr(addr8), .program_cmd(cmd8),
      .cpu_run(run8), .busy(busy8), .error(err8));

   program_loader #(.ADDR(4), .CODE(8)) u_dut4 (
      .clk(clk), .rst(rst), .in_data(d4_data), .in_valid(d4_valid), .in_ready(rdy4),
      .reload(d4_reload), .program_write(wr4), .program_addr(addr4), .program_cmd(cmd4),
      .cpu_run(run4), .busy(busy4), .error(err4));

   always #5 clk = ~clk;

   function automatic void check(input string nm, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Monitors: every write strobe pops one expected {addr, cmd} entry.
   always @(negedge clk) begin
      if (wr8) begin
         check("wr8_width", wr8_prev, 0);
         check("wr8_queued", q8.size() > 0, 1);
         if (q8.size() > 0) check("wr8_addr_cmd", (int'(addr8) << 16) | int'(cmd8), q8.pop_front());
      end
      wr8_prev = wr8;
   end

   always @(negedge clk) begin
      if (wr4) begin
         check("wr4_width", wr4_prev, 0);
         check("wr4_queued", q4.size() > 0, 1);
         if (q4.size() > 0) check("wr4_addr_cmd", (int'(addr4) << 16) | int'(cmd4), q4.pop_front());
      end
      wr4_prev = wr4;
   end

   task automatic send(input bit s4, input logic [7:0] b, input int unsigned gap);
      int unsigned n;
      n = 0;
      if (s4) begin d4_data = b; d4_valid = 1'b1; end
      else    begin d8_data = b; d8_valid = 1'b1; end
      while (!(s4 ? rdy4 : rdy8) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("send_timeout", n, 0);
      @(negedge clk);
      if (s4) d4_valid = 1'b0; else d8_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_end(input bit s4);
      int unsigned n;
      n = 0;
      while (!(s4 ? (run4 | err4) : (run8 | err8)) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("wait_end_timeout", n, 0);
   endtask

   task automatic pulse_reload(input bit s4);
      if (s4) d4_reload = 1'b1; else d8_reload = 1'b1;
      @(negedge clk);
      d4_reload = 1'b0;
      d8_reload = 1'b0;
   endtask

   // Sends a frame from lo_v/hi_v; expected cmd is {hi[3:0], lo}, addr is the word index mod 2^ADDR.
   task automatic frame(input bit s4, input logic [7:0] c, input int unsigned n,
                        input int unsigned gap, input bit bad_csum);
      logic [7:0] cs;
      int unsigned amask;
      amask = s4 ? 32'hF : 32'hFF;
      cs = c;
      send(s4, c, gap);
      for (int i = 0; i < int'(n); i++) begin
         send(s4, lo_v[i], gap);
         if (s4) q4.push_back(((i & amask) << 16) | {20'd0, hi_v[i][3:0], lo_v[i]});
         else    q8.push_back(((i & amask) << 16) | {20'd0, hi_v[i][3:0], lo_v[i]});
         send(s4, hi_v[i], 0);
         check("wr_latency", s4 ? wr4 : wr8, 1);
         cs = cs ^ lo_v[i] ^ hi_v[i];
         repeat (gap) @(negedge clk);
      end
`ifdef LOADER_CHECKSUM_EN
      send(s4, bad_csum ? 8'h00 : cs, 0);
`else
      if (bad_csum) cs = 8'h00;
`endif
   endtask

   task automatic check_reset8();
      check("rst_in_ready", rdy8, 1);
      check("rst_write", wr8, 0);
      check("rst_addr", addr8, 0);
      check("rst_cmd", cmd8, 0);
      check("rst_cpu_run", run8, 0);
      check("rst_busy", busy8, 0);
      check("rst_error", err8, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset8();
      check("rst4_in_ready", rdy4, 1);
      rst = 1'b1;
      @(negedge clk);

      // Basic two-word frame.
      lo_v[0] = 8'hA5; hi_v[0] = 8'h01;
      lo_v[1] = 8'h03; hi_v[1] = 8'h0C;
      frame(0, 8'd2, 2, 0, 0);
      wait_end(0);
      check("t1_cpu_run", run8, 1);
      check("t1_busy", busy8, 0);
      check("t1_error", err8, 0);
      check("t1_addr_after", addr8, 2);
      d8_data = 8'h55; d8_valid = 1'b1;
      repeat (4) @(negedge clk);
      check("t1_done_ready", rdy8, 0);
      check("t1_done_run", run8, 1);
      d8_valid = 1'b0;
      pulse_reload(0);
      check("t1_reload_ready", rdy8, 1);
      check("t1_reload_run", run8, 0);

      // in_valid toggled every other cycle; upper hi bits must be ignored.
      lo_v[0] = 8'hB7; hi_v[0] = 8'hF2;
      lo_v[1] = 8'hFF; hi_v[1] = 8'h00;
      lo_v[2] = 8'hFF; hi_v[2] = 8'h0F;
      frame(0, 8'd3, 3, 1, 0);
      wait_end(0);
      check("t2_cpu_run", run8, 1);
      check("t2_addr_after", addr8, 3);
      pulse_reload(0);

      // C=0 means 256 words; address wraps back to 0.
      for (int i = 0; i < 256; i++) begin
         lo_v[i] = 8'(i);
         hi_v[i] = 8'(i * 3 + 1);
      end
      frame(0, 8'd0, 256, 0, 0);
      wait_end(0);
      check("t3_cpu_run", run8, 1);
      check("t3_addr_wrap", addr8, 0);
      pulse_reload(0);

      // Reset after lo byte of word 2 of 3.
      send(0, 8'd3, 0);
      send(0, 8'h11, 0);
      q8.push_back(32'h0000_0211);
      send(0, 8'h02, 0);
      check("t4_latency", wr8, 1);
      send(0, 8'h22, 0);
      check("t4_busy_mid", busy8, 1);
      #2 rst = 1'b0;
      #1 check_reset8();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      lo_v[0] = 8'h5A; hi_v[0] = 8'h03;
      lo_v[1] = 8'h33; hi_v[1] = 8'h0E;
      lo_v[2] = 8'hC8; hi_v[2] = 8'h07;
      frame(0, 8'd3, 3, 0, 0);
      wait_end(0);
      check("t4_cpu_run", run8, 1);
      check("t4_addr_after", addr8, 3);
      pulse_reload(0);

`ifdef LOADER_CHECKSUM_EN
      // Wrong checksum: one strobe, then ERR.
      lo_v[0] = 8'hFF; hi_v[0] = 8'h00;
      frame(0, 8'd1, 1, 0, 1);
      wait_end(0);
      check("t5_error", err8, 1);
      check("t5_cpu_run", run8, 0);
      pulse_reload(0);
      check("t5_reload_error", err8, 0);
`endif

      // ADDR=4 instance: C=17 exceeds 16 words.
      send(1, 8'h11, 0);
      wait_end(1);
      check("t6_error", err4, 1);
      check("t6_cpu_run", run4, 0);
      check("t6_busy", busy4, 0);
      check("t6_ready", rdy4, 0);
      pulse_reload(1);
      check("t6_reload_error", err4, 0);
      check("t6_reload_ready", rdy4, 1);

      // C=16 is the largest legal count at ADDR=4.
      for (int i = 0; i < 16; i++) begin
         lo_v[i] = 8'(8'hE0 + i);
         hi_v[i] = 8'(8'h90 + i);
      end
      frame(1, 8'h10, 16, 0, 0);
      wait_end(1);
      check("t7_cpu_run", run4, 1);
      check("t7_error", err4, 0);
      check("t7_addr_wrap", addr4, 0);

      repeat (3) @(negedge clk);
      check("q8_drained", q8.size(), 0);
      check("q4_drained", q4.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      n_bad++;
      $display("FAIL global_timeout: simulation did not finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1);
   end

endmodule
